// File: rtl/alu_front_pkg.sv
// alu_front_pkg
//   Shared definitions for the ALU front end: the sequencer state
//   encoding, the blank 7-segment pattern and the hex-to-segment decoder.
//   No ports; imported by alu_front_seq and btn_debounce.
package alu_front_pkg;

    typedef enum logic [2:0] {
        S_A      = 3'd0,
        S_B      = 3'd1,
        S_OP     = 3'd2,
        S_SETTLE = 3'd3,
        S_SHOW   = 3'd4
    } state_t;

    // All segments and the decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low 7-segment pattern for one hex digit.
    // Bit 7 is dp (always off), bits 6..0 are g..a.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_front_btn_debounce.sv
// btn_debounce
//   Conditions one raw, asynchronous, bouncy push button:
//   2-flop synchronizer -> stability counter -> rising-edge pulse.
//   Ports:
//     clk, rst  system clock, asynchronous active-high reset
//     btn       raw button level
//     pulse     one-cycle pulse when the debounced level rises
//   A press held steady produces its pulse 2 + DEBOUNCE_CYCLES cycles
//   after the first clock edge that samples it.
module btn_debounce
    import alu_front_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            // Any sample that agrees with the accepted level restarts the
            // count, so only an unbroken run of disagreeing samples flips it.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_front_seq.sv
// alu_front_seq
//   Operand/command front end for a 4-bit ALU. Three debounced step
//   presses load operand A, operand B and the opcode; the front end then
//   holds them on the ALU inputs for SETTLE_CYCLES and captures the ALU's
//   result, carry and overflow, which are shown on two 7-segment digits.
//   Ports:
//     clk, rst            system clock, asynchronous active-high reset
//     sw_data[3:0]        operand switches
//     sw_op[2:0]          opcode switches
//     btn_step, btn_clr   raw step / clear buttons
//     alu_res/car/of      ALU outputs (consumed)
//     alu_a/b, alu_ctrl   ALU operands and opcode (produced)
//     seg0                value digit (active-low)
//     seg1                status digit (active-low)
//     busy                high while waiting for the ALU to settle
//     state_led[2:0]      one-hot S_A / S_B / S_OP indicator
//   ALU interface: there is no valid/ready pair. Issuing the opcode is the
//   "valid" event; the ALU is assumed ready, and its outputs are trusted
//   only on the single capture edge SETTLE_CYCLES edges later.
//   busy and state_led together expose the sequencer state.
module alu_front_seq
    import alu_front_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_data,
    input  logic [2:0] sw_op,
    input  logic       btn_step,
    input  logic       btn_clr,
    input  logic [3:0] alu_res,
    input  logic       alu_car,
    input  logic       alu_of,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic       busy,
    output logic [2:0] state_led
);

    localparam int CNTW = $clog2(SETTLE_CYCLES + 1);

    logic           step_p;
    logic           clr_p;
    state_t         state;
    logic [CNTW-1:0] cnt;
    logic [3:0]     res_q;
    logic           car_q;
    logic           of_q;
    logic [7:0]     seg0_n;
    logic [7:0]     seg1_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .pulse (step_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (clr_p)
    );

    // Sequencer. clr_p wins over step_p and aborts a pending capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_A;
            cnt      <= '0;
            alu_a    <= 4'h0;
            alu_b    <= 4'h0;
            alu_ctrl <= 3'h0;
            res_q    <= 4'h0;
            car_q    <= 1'b0;
            of_q     <= 1'b0;
        end else if (clr_p) begin
            state    <= S_A;
            cnt      <= '0;
            alu_a    <= 4'h0;
            alu_b    <= 4'h0;
            alu_ctrl <= 3'h0;
            res_q    <= 4'h0;
            car_q    <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (step_p) begin
                        alu_a <= sw_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (step_p) begin
                        alu_b <= sw_data;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (step_p) begin
                        alu_ctrl <= sw_op;
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // The ALU outputs are looked at on this edge only.
                    if (cnt == CNTW'(SETTLE_CYCLES - 1)) begin
                        res_q <= alu_res;
                        car_q <= alu_car;
                        of_q  <= alu_of;
                        state <= S_SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (step_p) begin
                        state <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    // Display contents for the current state; registered below.
    always_comb begin
        seg0_n = SEG_BLANK;
        seg1_n = SEG_BLANK;
        case (state)
            S_A: begin
                seg0_n = hex_to_seg(sw_data);
                seg1_n = hex_to_seg(4'h1);
            end
            S_B: begin
                seg0_n = hex_to_seg(sw_data);
                seg1_n = hex_to_seg(4'h2);
            end
            S_OP: begin
                seg0_n = hex_to_seg({1'b0, sw_op});
                seg1_n = hex_to_seg(4'h3);
            end
            S_SHOW: begin
                seg0_n = hex_to_seg(res_q);
                seg1_n = hex_to_seg({2'b00, of_q, car_q});
            end
            default: begin
                seg0_n = SEG_BLANK;
                seg1_n = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg0 <= SEG_BLANK;
            seg1 <= SEG_BLANK;
        end else begin
            seg0 <= seg0_n;
            seg1 <= seg1_n;
        end
    end

    assign busy = (state == S_SETTLE);

    always_comb begin
        state_led = 3'b000;
        case (state)
            S_A:     state_led = 3'b001;
            S_B:     state_led = 3'b010;
            S_OP:    state_led = 3'b100;
            default: state_led = 3'b000;
        endcase
    end

endmodule

// File: doc/alu_front_seq.md
Name: alu_front_seq

Overview:
Sequential operand/command front end that drives the 4-bit ALU from board switches and buttons. It collects operand A, operand B and the opcode in three debounced button steps, then presents them to the ALU and waits a fixed settle time. It captures the ALU result, carry and overflow and drives two active-low 7-segment digits. It is the producer side of the ALU's a/b/ctrl interface and the consumer of its res/car/of outputs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button level is accepted (>=2)
SETTLE_CYCLES, 2, cycles between issuing operands and capturing ALU outputs (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sw_data  in  4  operand switches
sw_op  in  3  opcode switches
btn_step  in  1  raw step button, asynchronous, bouncy
btn_clr  in  1  raw clear button, asynchronous, bouncy
alu_res  in  4  ALU result
alu_car  in  1  ALU carry
alu_of  in  1  ALU overflow
alu_a  out  4  operand A to ALU
alu_b  out  4  operand B to ALU
alu_ctrl  out  3  opcode to ALU
seg0  out  8  value digit, active-low; bit7=dp, bits6..0=g..a
seg1  out  8  status digit, same encoding
busy  out  1  high in S_SETTLE
state_led  out  3  one-hot: [0]=S_A, [1]=S_B, [2]=S_OP; all zero otherwise

Behaviour:
- Reset (async, active-high): state=S_A; alu_a=alu_b=0; alu_ctrl=0; captured res/car/of=0; debounce counters=0; stable button levels=0; busy=0; state_led=3'b001; seg0=seg1=8'hFF (blank).
- Buttons: each passes through a 2-flop synchronizer, then a debouncer. The counter clears whenever the synced level equals the stable level. Otherwise it increments; at DEBOUNCE_CYCLES-1 the stable level flips and the counter clears. A rising edge of the stable level produces a 1-cycle pulse (step_p / clr_p). Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- FSM:
  - S_A: step_p -> alu_a<=sw_data, go S_B.
  - S_B: step_p -> alu_b<=sw_data, go S_OP.
  - S_OP: step_p -> alu_ctrl<=sw_op, cnt<=0, go S_SETTLE.
  - S_SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, capture alu_res/alu_car/alu_of and go S_SHOW. step_p is ignored.
  - S_SHOW: step_p -> go S_A. Operands, opcode and captured values are held.
- clr_p in any state: go S_A; clear alu_a, alu_b, alu_ctrl and captured values; abort S_SETTLE with no capture. clr_p has priority over step_p in the same cycle.
- The ALU outputs are sampled only at the capture cycle. They are not sampled at any other time.
- Display: seg0 and seg1 are registered, so they update 1 cycle after a state or data change. The hex decode is standard active-low with dp off (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E).
  - seg0: S_A/S_B show hex(sw_data); S_OP shows hex({1'b0,sw_op}); S_SETTLE shows FF; S_SHOW shows hex(captured res).
  - seg1: S_A shows hex(1); S_B shows hex(2); S_OP shows hex(3); S_SETTLE shows FF; S_SHOW shows hex({2'b0,of,car}).
- busy and state_led are combinational from the state register.

Decomposition:
- Package alu_front_pkg holds:
  - the state enum (S_A, S_B, S_OP, S_SETTLE, S_SHOW);
  - SEG_BLANK=8'hFF;
  - a hex_to_seg function (4-bit -> 8-bit active-low).
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES and instantiated twice.

Test Plan:
- Reset held, then released with no buttons -> state_led=001, busy=0, all ALU outputs 0; one cycle after release seg0=hex(sw_data), seg1=F9.
- Sequence: sw_data=3, step; sw_data=5, step; sw_op=000, step; ALU model returns res=8, car=0, of=1 -> after SETTLE_CYCLES, S_SHOW with seg0=80, seg1=A4 (digit 2).
- Step pulses toggling every DEBOUNCE_CYCLES/2 cycles for 200 cycles -> no state change. Then hold the button -> exactly one advance, 2+DEBOUNCE_CYCLES cycles after the hold begins.
- Second step_p during S_SETTLE -> ignored; capture still occurs once, and state goes to S_SHOW, not S_A.
- clr and step debounced in the same cycle while in S_B with alu_a=7 -> state S_A, alu_a=0, seg1=F9.
- Async rst asserted mid-S_SETTLE (no clock edge) -> outputs immediately at reset values, no capture; operation restarts at S_A after release.
